// File: rtl/fifo_arbiter_pkg.sv
// Shared constants and helpers for the fifo push arbiter / pop sequencer slice.
package fifo_arbiter_pkg;

  localparam int unsigned OBUF_DEPTH = 2;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: search starts at ptr_q, pointer moves past the winner on advance.
module rr_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  localparam int unsigned IW = idx_width(NREQ)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] cand;
  logic          found;

  // ptr_q holds (last_grant + 1) mod NREQ, so reset to 0 makes producer 0 first.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = IW'((32'(ptr_q) + k) % NREQ);
      if (!found && req[cand]) begin
        found     = 1'b1;
        grant_idx = cand;
      end
    end
    grant = found ? (NREQ'(1) << grant_idx) : '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (grant_idx == IW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fifo_arbiter.sv
// Push arbiter for NREQ producers onto a shared fifo, plus pop sequencer and
// 2-entry output buffer that hides the fifo's 1-cycle read latency.
module fifo_arbiter
  import fifo_arbiter_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned NREQ  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         req_ready,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    fifo_push_en,
  output logic [WIDTH-1:0]        fifo_push_data,
  input  logic                    fifo_full,
  output logic                    fifo_pop_en,
  input  logic [WIDTH-1:0]        fifo_pop_data,
  input  logic                    fifo_empty,
  output logic                    out_valid,
  output logic [WIDTH-1:0]        out_data,
  input  logic                    out_ready
);

  localparam int unsigned IW = $clog2(NREQ);
  localparam int unsigned CW = $clog2(OBUF_DEPTH + 1);

  logic [NREQ-1:0]  arb_grant;
  logic [IW-1:0]    arb_idx;
  logic             fire;
  logic             inflight_q, inflight_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] buf_q [OBUF_DEPTH];
  logic [WIDTH-1:0] buf_d [OBUF_DEPTH];

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (fifo_push_en),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  // rst_n gates the combinational paths so outputs drop the moment reset asserts.
  always_comb begin
    fifo_push_en   = rst_n && !fifo_full && (|req_valid);
    req_ready      = fifo_push_en ? arb_grant : '0;
    grant_id       = fifo_push_en ? arb_idx : '0;
    fifo_push_data = req_data[arb_idx*WIDTH +: WIDTH];
  end

  always_comb begin
    fire        = (cnt_q != '0) && out_ready;
    fifo_pop_en = rst_n && !fifo_empty &&
                  ((3'(cnt_q) + 3'(inflight_q)) < (3'(OBUF_DEPTH) + 3'(fire)));
    inflight_d  = fifo_pop_en;
    out_valid   = (cnt_q != '0);
    out_data    = buf_q[0];
  end

  // Entry 0 is always the head; a capture lands in the first free slot after any shift.
  always_comb begin
    buf_d = buf_q;
    cnt_d = cnt_q;
    case ({fire, inflight_q})
      2'b10: begin
        buf_d[0] = buf_q[1];
        cnt_d    = cnt_q - 1'b1;
      end
      2'b01: begin
        if (cnt_q == '0) buf_d[0] = fifo_pop_data;
        else             buf_d[1] = fifo_pop_data;
        cnt_d = cnt_q + 1'b1;
      end
      2'b11: begin
        if (cnt_q == CW'(1)) begin
          buf_d[0] = fifo_pop_data;
        end else begin
          buf_d[0] = buf_q[1];
          buf_d[1] = fifo_pop_data;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight_q <= 1'b0;
      cnt_q      <= '0;
      for (int unsigned i = 0; i < OBUF_DEPTH; i++) buf_q[i] <= '0;
    end else begin
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      buf_q      <= buf_d;
    end
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    !(inflight_q && !fire && (cnt_q == CW'(OBUF_DEPTH))));

endmodule

// File: tb/tb_fifo_arbiter.sv
// Bench for fifo_arbiter with a depth-4 fifo model (sync reset, 1-cycle read latency).
module tb_fifo_arbiter;

  localparam int unsigned W  = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned FD = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready;
  logic [1:0]     grant_id;
  logic           fifo_push_en;
  logic [W-1:0]   fifo_push_data;
  logic           fifo_full;
  logic           fifo_pop_en;
  logic [W-1:0]   fifo_pop_data;
  logic           fifo_empty;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready = 1'b0;

  int total = 0;
  int bad   = 0;
  int n_out = 0;
  logic [W-1:0] exp_q [$];

  int unsigned  p_left [N];
  int unsigned  p_seq  [N];
  logic [W-1:0] p_base [N];

  always #5 clk = ~clk;

  fifo_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_data       (req_data),
    .req_ready      (req_ready),
    .grant_id       (grant_id),
    .fifo_push_en   (fifo_push_en),
    .fifo_push_data (fifo_push_data),
    .fifo_full      (fifo_full),
    .fifo_pop_en    (fifo_pop_en),
    .fifo_pop_data  (fifo_pop_data),
    .fifo_empty     (fifo_empty),
    .out_valid      (out_valid),
    .out_data       (out_data),
    .out_ready      (out_ready)
  );

  logic [W-1:0] fmem [FD];
  int unsigned  fcnt = 0, frd = 0, fwr = 0;
  logic [W-1:0] f_pop_data = '0;
  logic         do_push, do_pop;

  assign fifo_full     = (fcnt == FD);
  assign fifo_empty    = (fcnt == 0);
  assign fifo_pop_data = f_pop_data;
  assign do_push       = fifo_push_en && (fcnt < FD);
  assign do_pop        = fifo_pop_en && (fcnt != 0);

  always @(posedge clk) begin
    if (!rst_n) begin
      fcnt <= 0; frd <= 0; fwr <= 0; f_pop_data <= '0;
    end else begin
      if (do_push) begin fmem[fwr] <= fifo_push_data; fwr <= (fwr + 1) % FD; end
      if (do_pop)  begin f_pop_data <= fmem[frd]; frd <= (frd + 1) % FD; end
      fcnt <= fcnt + (do_push ? 1 : 0) - (do_pop ? 1 : 0);
    end
  end

  // Scoreboard pop side plus fifo flag protocol.
  always @(negedge clk) begin
    logic [W-1:0] exp_w;
    if (rst_n) begin
      total++;
      if ((fifo_push_en && fifo_full) || (fifo_pop_en && fifo_empty)) begin
        bad++;
        $display("FAIL fifo_flags push_en=%0b full=%0b pop_en=%0b empty=%0b required no push when full and no pop when empty",
                 fifo_push_en, fifo_full, fifo_pop_en, fifo_empty);
      end
      if (out_valid && out_ready) begin
        n_out++;
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL sb_extra got=%02h required=no word", out_data);
        end else begin
          exp_w = exp_q.pop_front();
          if (out_data !== exp_w) begin
            bad++;
            $display("FAIL sb_data got=%02h required=%02h", out_data, exp_w);
          end
        end
      end
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = (p_left[i] != 0);
      req_data[i*W +: W] = p_base[i] + W'(p_seq[i]);
    end
  endtask

  // One clock: record transfers before the edge, advance producers just after it.
  task automatic step(output int unsigned took_n);
    logic [N-1:0] took;
    @(negedge clk);
    took   = req_valid & req_ready;
    took_n = 0;
    for (int i = 0; i < N; i++) begin
      if (took[i]) begin
        exp_q.push_back(req_data[i*W +: W]);
        took_n++;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) begin
      if (took[i]) begin
        p_seq[i]++;
        p_left[i]--;
      end
    end
    drive();
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) begin
      p_left[i] = 0; p_seq[i] = 0; p_base[i] = '0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1;
    exp_q.delete();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    int unsigned tk;
    total++;
    if ({out_valid, req_ready, fifo_push_en, fifo_pop_en, grant_id} !== '0 || out_data !== '0) begin
      bad++;
      $display("FAIL reset_state out_valid=%0b out_data=%02h req_ready=%b push_en=%0b pop_en=%0b grant_id=%0d required all zero",
               out_valid, out_data, req_ready, fifo_push_en, fifo_pop_en, grant_id);
    end
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin p_base[i] = 8'(16 * i); p_left[i] = 20; end
    drive();
    #1;
    repeat (6) step(tk);
    total++;
    if (fifo_push_en !== 1'b1 || fifo_pop_en !== 1'b1) begin
      bad++;
      $display("FAIL reset_active push_en=%0b pop_en=%0b required 1 1", fifo_push_en, fifo_pop_en);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (req_ready !== '0 || fifo_push_en !== 1'b0 || fifo_pop_en !== 1'b0 || out_valid !== 1'b0) begin
      bad++;
      $display("FAIL reset_async req_ready=%b push_en=%0b pop_en=%0b out_valid=%0b required all zero",
               req_ready, fifo_push_en, fifo_pop_en, out_valid);
    end
    apply_reset();
  endtask

  task automatic test_single();
    int unsigned tk;
    int base_n;
    logic exp_v;
    apply_reset();
    out_ready = 1'b1;
    p_base[1] = 8'hA5;
    p_left[1] = 1;
    drive();
    #1;
    base_n = n_out;
    for (int c = 0; c < 6; c++) begin
      exp_v = (c == 3);
      total++;
      if (out_valid !== exp_v) begin
        bad++;
        $display("FAIL single_valid cycle=%0d got=%0b required=%0b", c, out_valid, exp_v);
      end
      if (c == 0) begin
        total++;
        if (req_ready !== 4'b0010 || grant_id !== 2'd1 || fifo_push_en !== 1'b1 || fifo_push_data !== 8'hA5) begin
          bad++;
          $display("FAIL single_push req_ready=%b grant_id=%0d push_en=%0b push_data=%02h required 0010 1 1 a5",
                   req_ready, grant_id, fifo_push_en, fifo_push_data);
        end
      end
      if (c == 1) begin
        total++;
        if (fifo_pop_en !== 1'b1) begin
          bad++;
          $display("FAIL single_pop got=%0b required=1", fifo_pop_en);
        end
      end
      if (c == 3) begin
        total++;
        if (out_data !== 8'hA5) begin
          bad++;
          $display("FAIL single_data got=%02h required=a5", out_data);
        end
      end
      step(tk);
    end
    total++;
    if (n_out - base_n != 1) begin
      bad++;
      $display("FAIL single_count got=%0d required=1", n_out - base_n);
    end
  endtask

  task automatic test_fairness();
    int unsigned tk;
    int k, j, first, last, nv;
    logic [W-1:0] exp_d;
    apply_reset();
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) begin p_base[i] = 8'(16 * i); p_left[i] = 4; end
    drive();
    #1;
    k = 0; j = 0; first = -1; last = -1; nv = 0;
    for (int c = 0; c < 40; c++) begin
      if (fifo_push_en) begin
        total++;
        if (grant_id !== 2'(k % 4) || req_ready !== 4'(1 << (k % 4))) begin
          bad++;
          $display("FAIL fair_grant n=%0d grant_id=%0d req_ready=%b required id=%0d", k, grant_id, req_ready, k % 4);
        end
        k++;
      end
      if (out_valid) begin
        exp_d = 8'(16 * (j % 4) + j / 4);
        total++;
        if (out_data !== exp_d) begin
          bad++;
          $display("FAIL fair_data n=%0d got=%02h required=%02h", j, out_data, exp_d);
        end
        j++;
        if (first < 0) first = c;
        last = c;
        nv++;
      end
      step(tk);
    end
    total++;
    if (k != 16 || nv != 16 || last - first + 1 != 16) begin
      bad++;
      $display("FAIL fair_rate grants=%0d outputs=%0d span=%0d required 16 16 16", k, nv, last - first + 1);
    end
  endtask

  task automatic test_full();
    int unsigned tk, acc;
    int base_n;
    apply_reset();
    out_ready = 1'b0;
    p_base[0] = 8'h40;
    p_left[0] = 10;
    drive();
    #1;
    base_n = n_out;
    acc = 0;
    for (int c = 0; c < 20; c++) begin
      step(tk);
      acc += tk;
    end
    total++;
    if (acc != 6) begin
      bad++;
      $display("FAIL full_accepted got=%0d required=6", acc);
    end
    total++;
    if (req_ready !== '0 || fifo_push_en !== 1'b0 || fifo_full !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'h40) begin
      bad++;
      $display("FAIL full_stall req_ready=%b push_en=%0b full=%0b out_valid=%0b out_data=%02h required 0000 0 1 1 40",
               req_ready, fifo_push_en, fifo_full, out_valid, out_data);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 60 && (p_left[0] != 0 || exp_q.size() != 0); c++) step(tk);
    total++;
    if (p_left[0] != 0 || exp_q.size() != 0 || n_out - base_n != 10) begin
      bad++;
      $display("FAIL full_drain left=%0d pending=%0d outputs=%0d required 0 0 10", p_left[0], exp_q.size(), n_out - base_n);
    end
  endtask

  task automatic test_backpressure();
    int unsigned tk, busy;
    int base_n;
    apply_reset();
    for (int i = 0; i < N; i++) begin p_base[i] = 8'(64 * i); p_left[i] = 8; end
    drive();
    #1;
    base_n = n_out;
    busy = 1;
    for (int c = 0; c < 400 && busy != 0; c++) begin
      out_ready = (c < 16) ? ((c % 2) == 0) : 1'($urandom_range(0, 1));
      step(tk);
      busy = exp_q.size();
      for (int i = 0; i < N; i++) busy += p_left[i];
    end
    total++;
    if (busy != 0 || n_out - base_n != 32) begin
      bad++;
      $display("FAIL bp_complete outstanding=%0d outputs=%0d required 0 32", busy, n_out - base_n);
    end
  endtask

  task automatic test_reset_mid();
    int unsigned tk;
    int base_n;
    logic exp_v;
    apply_reset();
    out_ready = 1'b0;
    p_base[2] = 8'h70;
    p_left[2] = 3;
    drive();
    #1;
    repeat (8) step(tk);
    total++;
    if (out_valid !== 1'b1 || out_data !== 8'h70) begin
      bad++;
      $display("FAIL mid_loaded out_valid=%0b out_data=%02h required 1 70", out_valid, out_data);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out_data !== '0 || fifo_pop_en !== 1'b0 || req_ready !== '0) begin
      bad++;
      $display("FAIL mid_async out_valid=%0b out_data=%02h pop_en=%0b req_ready=%b required all zero",
               out_valid, out_data, fifo_pop_en, req_ready);
    end
    apply_reset();
    out_ready = 1'b1;
    base_n = n_out;
    for (int c = 0; c < 3; c++) begin
      total++;
      if (out_valid !== 1'b0 || out_data !== '0) begin
        bad++;
        $display("FAIL mid_quiet cycle=%0d out_valid=%0b out_data=%02h required 0 00", c, out_valid, out_data);
      end
      step(tk);
    end
    p_base[3] = 8'h5A;
    p_left[3] = 1;
    drive();
    #1;
    for (int c = 0; c < 6; c++) begin
      exp_v = (c == 3);
      total++;
      if (out_valid !== exp_v || (exp_v && out_data !== 8'h5A)) begin
        bad++;
        $display("FAIL mid_word cycle=%0d out_valid=%0b out_data=%02h required valid=%0b data=5a",
                 c, out_valid, out_data, exp_v);
      end
      step(tk);
    end
    total++;
    if (n_out - base_n != 1) begin
      bad++;
      $display("FAIL mid_stale outputs=%0d required=1", n_out - base_n);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < N; i++) begin p_left[i] = 0; p_seq[i] = 0; p_base[i] = '0; end
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_fairness();
    test_full();
    test_backpressure();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
